// File: rtl/simd_lsu.sv
// SIMD load/store issue unit: snapshots one per-lane command and drives the shared memory controller.
// Optional watchdog (err port, TIMEOUT_CYC) is built only when LSU_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start; snapshot loaded on start
// ISSUE   | request driven, waiting for controller to drop MReady
// WAIT    | request held, waiting for MReady to return high
// CAPTURE | one-cycle done pulse; load results latched at end of cycle
module simd_lsu #(
  parameter int N_CORES     = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        is_write,
  input  logic [N_CORES-1:0]          core_en,
  input  logic [N_CORES*ADDR_W-1:0]   core_addr,
  input  logic [N_CORES*DATA_W-1:0]   core_wdata,
  output logic                        busy,
  output logic                        done,
  output logic [N_CORES*DATA_W-1:0]   core_rdata,
  output logic                        MRead,
  output logic                        MWrite,
  output logic [N_CORES-1:0]          en,
  output logic [N_CORES*ADDR_W-1:0]   addr,
  output logic [N_CORES*DATA_W-1:0]   data,
  input  logic [N_CORES*DATA_W-1:0]   q,
  input  logic                        MReady
`ifdef LSU_TIMEOUT_EN
  ,
  output logic                        err
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  state_t                      state, state_nxt;
  logic                        op_write;
  logic [N_CORES-1:0]          op_en;
  logic [N_CORES*ADDR_W-1:0]   op_addr;
  logic [N_CORES*DATA_W-1:0]   op_wdata;
  logic                        timed_out;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wd_cnt;
  logic             to_fire;
`endif

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    MRead     = 1'b0;
    MWrite    = 1'b0;
    en        = '0;
    addr      = '0;
    data      = '0;
`ifdef LSU_TIMEOUT_EN
    to_fire   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) state_nxt = (core_en == '0) ? CAPTURE : ISSUE;
      end
      ISSUE, WAIT: begin
        MRead  = !op_write;
        MWrite = op_write;
        en     = op_en;
        addr   = op_addr;
        data   = op_wdata;
        // MReady already low in ISSUE counts as acceptance (single master)
        if (state == ISSUE && !MReady) state_nxt = WAIT;
        if (state == WAIT && MReady)   state_nxt = CAPTURE;
      end
      CAPTURE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
`ifdef LSU_TIMEOUT_EN
    if ((state == ISSUE || state == WAIT) && wd_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
      to_fire   = 1'b1;
      state_nxt = CAPTURE;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      op_write   <= 1'b0;
      op_en      <= '0;
      op_addr    <= '0;
      op_wdata   <= '0;
      core_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        op_write <= is_write;
        op_en    <= core_en;
        op_addr  <= core_addr;
        op_wdata <= core_wdata;
      end
      if (state == CAPTURE && !op_write && !timed_out) begin
        for (int i = 0; i < N_CORES; i++)
          if (op_en[i]) core_rdata[i*DATA_W +: DATA_W] <= q[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef LSU_TIMEOUT_EN
  // counter clears while idle so it starts at zero on entry to ISSUE
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt    <= '0;
      err       <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      if (state == IDLE)                       wd_cnt <= '0;
      else if (state == ISSUE || state == WAIT) wd_cnt <= wd_cnt + CNT_W'(1);
      if (to_fire) begin
        err       <= 1'b1;
        timed_out <= 1'b1;
      end else if (state == IDLE) begin
        timed_out <= 1'b0;
      end
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYC;
  assign timed_out      = 1'b0;
`endif

endmodule

// File: tb/tb_simd_lsu.sv
// Self-checking bench for simd_lsu: behavioural controller model plus a core_rdata scoreboard.
// The watchdog scenario is exercised only when LSU_TIMEOUT_EN is defined.
module tb_simd_lsu;
  localparam int NC = 4;
  localparam int AW = 16;
  localparam int DW = 16;
`ifdef LSU_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic             clock = 1'b0;
  logic             reset, start, is_write;
  logic [NC-1:0]    core_en;
  logic [NC*AW-1:0] core_addr;
  logic [NC*DW-1:0] core_wdata;
  logic             busy, done, MRead, MWrite, MReady;
  logic [NC*DW-1:0] core_rdata, data, q;
  logic [NC-1:0]    en;
  logic [NC*AW-1:0] addr;
`ifdef LSU_TIMEOUT_EN
  logic             err;
`endif

  simd_lsu #(.N_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .is_write(is_write),
    .core_en(core_en), .core_addr(core_addr), .core_wdata(core_wdata),
    .busy(busy), .done(done), .core_rdata(core_rdata),
    .MRead(MRead), .MWrite(MWrite), .en(en), .addr(addr), .data(data),
    .q(q), .MReady(MReady)
`ifdef LSU_TIMEOUT_EN
    , .err(err)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int svc_cyc = 0;
  logic [63:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // controller model: accepts while ready, holds MReady low svc_cyc cycles, returns addr+0x100
  initial begin
    int left;
    left   = 0;
    MReady = 1'b1;
    q      = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        MReady = 1'b1;
        left   = 0;
      end else if (MReady) begin
        if ((MRead || MWrite) && svc_cyc > 0) begin
          MReady = 1'b0;
          left   = svc_cyc;
        end
      end else begin
        left--;
        if (left == 0) begin
          for (int i = 0; i < NC; i++)
            q[i*DW +: DW] = en[i] ? addr[i*AW +: AW] + 16'h0100 : 16'hDEAD;
          MReady = 1'b1;
        end
      end
    end
  end

  // scoreboard: core_rdata checked the cycle after each done pulse
  initial begin
    bit pend;
    logic [63:0] e;
    pend = 0;
    forever begin
      @(negedge clock);
      if (reset) pend = 0;
      else if (pend) begin
        pend = 0;
        if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          chk("rdata", core_rdata, e);
        end
      end
      if (done && !reset) pend = 1;
    end
  end

  task automatic run_op(input string tag, input logic w, input logic [NC-1:0] m,
                        input logic [NC*AW-1:0] a, input logic [NC*DW-1:0] wd,
                        input logic [63:0] exp_rd, input int svc, input int exp_lat);
    logic [NC*DW+NC*AW+NC+1:0] exp_req;
    int lat, ndone, reqbad, nbusy;
    @(negedge clock);
    svc_cyc = svc;
    start = 1'b1; is_write = w; core_en = m; core_addr = a; core_wdata = wd;
    sb.push_back(exp_rd);
    exp_req = {~w, w, m, a, wd};
    lat = 0; ndone = 0; reqbad = 0; nbusy = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (i == 1) begin
        is_write = ~w; core_en = ~m;
        core_addr = {$urandom, $urandom}; core_wdata = {$urandom, $urandom};
      end
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat == 0) lat = i;
        if ({MRead, MWrite, en} != '0) reqbad++;
        start = 1'b1;
        core_en = '1;
      end else if (busy) begin
        if ({MRead, MWrite, en, addr, data} !== exp_req) reqbad++;
        if (i == 3) start = 1'b1;
      end
      if (lat != 0 && i >= lat + 3) break;
    end
    start = 1'b0;
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_ndone"}, 64'(ndone), 64'd1);
    chk({tag, "_req"}, 64'(reqbad), 64'd0);
    chk({tag, "_busy"}, 64'(nbusy), 64'(exp_lat));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_write = 1'b0;
    core_en = '0; core_addr = '0; core_wdata = '0;
    repeat (3) @(negedge clock);
    chk("rst_ctl", {busy, done, MRead, MWrite, en}, 64'd0);
    chk("rst_rdata", core_rdata, 64'd0);
    reset = 1'b0;

    run_op("store", 1'b1, 4'b0101, 64'h0053_0052_0051_0050,
           64'h2222_5555_1111_AAAA, 64'h0, 3, 5);
    run_op("ld_all", 1'b0, 4'b1111, 64'h0013_0012_0011_0010,
           64'h0, 64'h0113_0112_0111_0110, 4, 6);
    run_op("ld_l1", 1'b0, 4'b0010, 64'h0099_0098_0021_0097,
           64'h0, 64'h0113_0112_0121_0110, 1, 3);
    run_op("zero", 1'b0, 4'b0000, 64'h0044_0043_0042_0041,
           64'h0, 64'h0113_0112_0121_0110, 2, 1);

    // reset while the request is outstanding
    @(negedge clock);
    svc_cyc = 6;
    start = 1'b1; is_write = 1'b0; core_en = 4'hF; core_addr = 64'h0043_0042_0041_0040;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    chk("pre_rst_mread", {63'd0, MRead}, 64'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_ctl", {busy, done, MRead, MWrite, en}, 64'd0);
    chk("mid_rst_addr", addr, 64'd0);
    chk("mid_rst_data", data, 64'd0);
    chk("mid_rst_rdata", core_rdata, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    run_op("ld_post_rst", 1'b0, 4'b1111, 64'h0033_0032_0031_0030,
           64'h0, 64'h0133_0132_0131_0130, 2, 4);

`ifdef LSU_TIMEOUT_EN
    chk("err_clear", {63'd0, err}, 64'd0);
    run_op("wdog", 1'b0, 4'b1111, 64'h0063_0062_0061_0060,
           64'h0, 64'h0133_0132_0131_0130, 0, TO + 1);
    chk("err_set", {63'd0, err}, 64'd1);
    repeat (5) @(negedge clock);
    chk("err_sticky", {63'd0, err}, 64'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("err_rst", {63'd0, err}, 64'd0);
    reset = 1'b0;
`endif

    repeat (4) @(negedge clock);
    chk("sb_left", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/simd_lsu.md
Name: simd_lsu

Overview:
- SIMD load/store issue unit; sits directly upstream of the shared memory controller. The controller serialises per-core accesses onto the single memory port.
- Takes one load or store command from the control unit for all enabled lanes.
- Snapshots the per-lane addresses and write data, drives the controller's MRead/MWrite/en/addr/data request and tracks the MReady handshake.
- Captures per-lane load results and pulses done to the control unit.

Parameters:
- N_CORES, 4: number of lanes; must match the memory controller.
- ADDR_W, 16: address width per lane.
- DATA_W, 16: data width per lane.
- TIMEOUT_CYC, 64: watchdog limit in cycles. Used only when LSU_TIMEOUT_EN is defined.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe from the control unit; honoured only in IDLE.
- is_write  in  1  1 = store, 0 = load; sampled with start.
- core_en  in  N_CORES  lane mask; sampled with start.
- core_addr  in  N_CORES*ADDR_W  lane i at [i*ADDR_W +: ADDR_W].
- core_wdata  in  N_CORES*DATA_W  store data; lane i at [i*DATA_W +: DATA_W].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- core_rdata  out  N_CORES*DATA_W  latched load results per lane.
- MRead  out  1  read request to the controller.
- MWrite  out  1  write request to the controller.
- en  out  N_CORES  lane enables to the controller.
- addr  out  N_CORES*ADDR_W  per-lane addresses to the controller.
- data  out  N_CORES*DATA_W  per-lane write data to the controller.
- q  in  N_CORES*DATA_W  per-lane read data from the controller.
- MReady  in  1  controller idle/ready.
- err  out  1  watchdog error; present only with LSU_TIMEOUT_EN.

Behaviour:
- Reset, sync, takes priority over all else. Next edge: state = IDLE; busy, done, MRead, MWrite, en, addr, data, core_rdata, err all 0. Any in-flight request is dropped.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE:
  - start=1 latches is_write, core_en, core_addr and core_wdata into snapshot registers.
  - If core_en == 0, go to CAPTURE with no request issued (zero-lane op).
  - Otherwise go to ISSUE.
  - start=0: stay in IDLE.
- ISSUE:
  - MRead = !op_write, MWrite = op_write; never both high.
  - en/addr/data driven from the snapshot.
  - Stay until MReady == 0 (controller accepted), then go to WAIT.
- WAIT:
  - Request signals held unchanged; the controller samples MRead/MWrite in every lane state.
  - When MReady == 1, go to CAPTURE.
- CAPTURE (exactly one cycle):
  - MRead = MWrite = 0; en = 0.
  - done = 1.
  - For loads: core_rdata lane i <= q lane i for every lane with op_en[i] = 1. Disabled lanes hold their previous value. Stores leave core_rdata unchanged.
  - Next state IDLE.
- start outside IDLE is ignored; it is neither queued nor does it disturb the snapshot.
- Snapshot is stable for the whole op; core_* inputs may change after the start cycle.
- Latency: start sampled at edge T → MRead/MWrite high from T+1 → done high for one cycle one edge after MReady first returns high. Minimum total 4 cycles with a 1-lane controller service. Zero-lane op: done at T+1.
- Back-to-back: start may be asserted in the cycle done is high. It is ignored (state is CAPTURE); the earliest accepted start is in the following IDLE cycle.
- MReady already low on entry to ISSUE (controller still finishing another master): the unit treats this as acceptance. This is a legal single-master system only; multiple masters are out of scope.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ISSUE and increments every cycle in ISSUE or WAIT.
  - If it reaches TIMEOUT_CYC, go to CAPTURE and pulse done.
  - MRead/MWrite are released and core_rdata is not updated.
  - err is set sticky; it clears only on reset.
  - Counter width is $clog2(TIMEOUT_CYC+1).
- Undefined: no counter, no err port; the unit waits indefinitely in ISSUE/WAIT.

Test Plan:
- Load, 4 lanes, addrs 0x10/0x11/0x12/0x13; controller model returns q = addr+0x100 after 4 cycles MReady low → MRead held high until MReady rises; core_rdata = 0x110/0x111/0x112/0x113; single done pulse; MWrite never high.
- Store, core_en = 4'b0101, wdata lanes 0xAAAA/0x5555 → MWrite high, en = 0101, data stable through WAIT; core_rdata unchanged from reset value 0; done once.
- Load with core_en = 4'b0010 after a prior full load → only lane 1 of core_rdata updates; lanes 0/2/3 retain prior values.
- core_en = 0 with start → no MRead/MWrite ever; done one cycle after start; busy high exactly one cycle.
- Reset asserted in WAIT with MRead high → next edge: all outputs 0, IDLE. A subsequent start is accepted normally.
- LSU_TIMEOUT_EN, TIMEOUT_CYC = 8, MReady stuck at 1 → done and err at cycle 9 after ISSUE entry; MRead dropped; err stays 1 until reset.
